// File: rtl/fifo_adv.sv
// Single-clock FIFO with programmable almost-full/almost-empty levels, sticky
// overflow/underflow flags, synchronous flush and selectable registered or FWFT read.
module fifo_adv #(
  parameter int N_BITS    = 8,
  parameter int N_SIZE    = 4,
  parameter int AF_THRESH = N_SIZE - 1,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic                         err_clr,
  input  logic [N_BITS-1:0]            data_in,
  output logic [N_BITS-1:0]            data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(N_SIZE+1)-1:0]  count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(N_SIZE + 1);
  localparam int PW = $clog2(N_SIZE);

  logic [N_BITS-1:0] mem [N_SIZE];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              pop_ok;
  logic              push_ok;
  logic              ovf_evt;
  logic              udf_evt;

  // Pointers wrap explicitly so depths that are not a power of two work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N_SIZE - 1)) ? '0 : p + PW'(1);
  endfunction

  assign count        = count_q;
  assign full         = (count_q == CW'(N_SIZE));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));

  // Flush masks both requests and any errors they would otherwise raise.
  assign pop_ok  = !flush && pop && !empty;
  assign push_ok = !flush && push && (!full || pop_ok);
  assign ovf_evt = !flush && push && full && !pop_ok;
  assign udf_evt = !flush && pop && empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A fresh error in the same cycle as err_clr keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt || (overflow && !err_clr);
      underflow <= udf_evt || (underflow && !err_clr);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [N_BITS-1:0] dout_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
        end else if (flush) begin
          dout_q <= '0;
        end else if (pop_ok) begin
          dout_q <= mem[rd_ptr];
        end
      end

      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_adv.sv
// Directed bench for fifo_adv: a registered-read and an FWFT instance share stimulus
// and are checked against hand-computed values after each clock edge.
module tb_fifo_adv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push, pop, flush, err_clr;
  logic [7:0] data_in;

  logic [7:0] data_out_0, data_out_1;
  logic       full_0, empty_0, af_0, ae_0, ovf_0, udf_0;
  logic       full_1, empty_1, af_1, ae_1, ovf_1, udf_1;
  logic [2:0] count_0, count_1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_adv #(.N_BITS(8), .N_SIZE(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) dut_reg (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush), .err_clr(err_clr),
    .data_in(data_in), .data_out(data_out_0), .full(full_0), .empty(empty_0),
    .almost_full(af_0), .almost_empty(ae_0), .count(count_0),
    .overflow(ovf_0), .underflow(udf_0)
  );

  fifo_adv #(.N_BITS(8), .N_SIZE(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush), .err_clr(err_clr),
    .data_in(data_in), .data_out(data_out_1), .full(full_1), .empty(empty_1),
    .almost_full(af_1), .almost_empty(ae_1), .count(count_1),
    .overflow(ovf_1), .underflow(udf_1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic p_push, input logic p_pop, input logic p_flush,
                      input logic p_clr, input logic [7:0] p_data);
    push    = p_push;
    pop     = p_pop;
    flush   = p_flush;
    err_clr = p_clr;
    data_in = p_data;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    err_clr = 1'b0;
    data_in = 8'h00;
  endtask

  task automatic chk_status(input string tag, input logic [2:0] c, input logic f,
                            input logic e, input logic a_f, input logic a_e);
    chk({tag, ".count"}, 32'(count_0), 32'(c));
    chk({tag, ".full"}, 32'(full_0), 32'(f));
    chk({tag, ".empty"}, 32'(empty_0), 32'(e));
    chk({tag, ".af"}, 32'(af_0), 32'(a_f));
    chk({tag, ".ae"}, 32'(ae_0), 32'(a_e));
    chk({tag, ".count_fwft"}, 32'(count_1), 32'(c));
  endtask

  task automatic chk_err(input string tag, input logic o, input logic u);
    chk({tag, ".ovf"}, 32'(ovf_0), 32'(o));
    chk({tag, ".udf"}, 32'(udf_0), 32'(u));
    chk({tag, ".ovf_fwft"}, 32'(ovf_1), 32'(o));
    chk({tag, ".udf_fwft"}, 32'(udf_1), 32'(u));
  endtask

  initial begin
    rst_n   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    err_clr = 1'b0;
    data_in = 8'h00;
    #3;
    chk_status("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_err("reset", 1'b0, 1'b0);
    chk("reset.dout", 32'(data_out_0), 32'h0);
    chk("reset.dout_fwft", 32'(data_out_1), 32'h0);
    #4 rst_n = 1'b1;

    // single word round trip
    step(1, 0, 0, 0, 8'hFF);
    chk_status("push_ff", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("push_ff.dout", 32'(data_out_0), 32'h0);
    chk("push_ff.dout_fwft", 32'(data_out_1), 32'hFF);
    step(0, 1, 0, 0, 8'h00);
    chk("pop_ff.dout", 32'(data_out_0), 32'hFF);
    chk_status("pop_ff", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("pop_ff.dout_fwft", 32'(data_out_1), 32'h0);

    // fill, thresholds, overflow
    step(1, 0, 0, 0, 8'h1F);
    step(1, 0, 0, 0, 8'h2F);
    chk_status("fill2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1, 0, 0, 0, 8'h3F);
    chk_status("fill3", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1, 0, 0, 0, 8'h4F);
    chk_status("fill4", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_err("fill4", 1'b0, 1'b0);
    step(1, 0, 0, 0, 8'h5F);
    chk_status("ovf", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_err("ovf", 1'b1, 1'b0);
    chk("ovf.dout_fwft", 32'(data_out_1), 32'h1F);
    step(0, 1, 0, 0, 8'h00);
    chk("pop1.dout", 32'(data_out_0), 32'h1F);
    chk("pop1.dout_fwft", 32'(data_out_1), 32'h2F);
    step(0, 1, 0, 0, 8'h00);
    chk("pop2.dout", 32'(data_out_0), 32'h2F);
    step(0, 1, 0, 0, 8'h00);
    chk("pop3.dout", 32'(data_out_0), 32'h3F);
    chk_status("pop3", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(0, 1, 0, 0, 8'h00);
    chk("pop4.dout", 32'(data_out_0), 32'h4F);
    chk_status("pop4", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_err("pop4", 1'b1, 1'b0);
    step(0, 0, 0, 1, 8'h00);
    chk_err("clr_ovf", 1'b0, 1'b0);

    // full with simultaneous push and pop, pointers wrap
    step(1, 0, 0, 0, 8'h11);
    step(1, 0, 0, 0, 8'h22);
    step(1, 0, 0, 0, 8'h33);
    step(1, 0, 0, 0, 8'h44);
    chk_status("refill", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1, 1, 0, 0, 8'h6F);
    chk("pp1.dout", 32'(data_out_0), 32'h11);
    chk_status("pp1", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1, 1, 0, 0, 8'h6F);
    chk("pp2.dout", 32'(data_out_0), 32'h22);
    step(1, 1, 0, 0, 8'h6F);
    chk("pp3.dout", 32'(data_out_0), 32'h33);
    step(1, 1, 0, 0, 8'h6F);
    chk("pp4.dout", 32'(data_out_0), 32'h44);
    chk_status("pp4", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_err("pp4", 1'b0, 1'b0);
    chk("pp4.dout_fwft", 32'(data_out_1), 32'h6F);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 8'h00);
      chk($sformatf("drain%0d.dout", i), 32'(data_out_0), 32'h6F);
    end
    chk_status("drained", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    // empty with simultaneous push and pop
    step(1, 1, 0, 0, 8'h7F);
    chk_status("ep", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_err("ep", 1'b0, 1'b1);
    chk("ep.dout", 32'(data_out_0), 32'h6F);
    chk("ep.dout_fwft", 32'(data_out_1), 32'h7F);
    step(0, 0, 0, 1, 8'h00);
    chk_err("clr_udf", 1'b0, 1'b0);
    chk("clr_udf.count", 32'(count_0), 32'd1);
    // new error in the same cycle as err_clr wins
    step(0, 1, 0, 0, 8'h00);
    chk("pop7f.dout", 32'(data_out_0), 32'h7F);
    step(0, 1, 0, 1, 8'h00);
    chk_err("clr_vs_udf", 1'b0, 1'b1);
    step(0, 0, 0, 1, 8'h00);
    chk_err("clr_again", 1'b0, 1'b0);

    // FWFT exposure
    step(1, 0, 0, 0, 8'hA5);
    chk("fwft_push.dout", 32'(data_out_1), 32'hA5);
    chk("fwft_push.empty", 32'(empty_1), 32'h0);
    step(0, 0, 0, 0, 8'h00);
    chk("fwft_hold.dout", 32'(data_out_1), 32'hA5);
    step(0, 1, 0, 0, 8'h00);
    chk("fwft_pop.dout", 32'(data_out_1), 32'h0);
    chk("fwft_pop.empty", 32'(empty_1), 32'h1);
    chk("fwft_pop.dout_reg", 32'(data_out_0), 32'hA5);

    // flush beats push
    step(1, 0, 0, 0, 8'h01);
    step(1, 0, 0, 0, 8'h02);
    step(1, 0, 0, 0, 8'h03);
    chk_status("pre_flush", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1, 0, 1, 0, 8'hEE);
    chk_status("flush", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_err("flush", 1'b0, 1'b0);
    chk("flush.dout", 32'(data_out_0), 32'h0);
    chk("flush.dout_fwft", 32'(data_out_1), 32'h0);
    step(1, 0, 0, 0, 8'h55);
    chk("post_flush.dout_fwft", 32'(data_out_1), 32'h55);
    chk("post_flush.count", 32'(count_0), 32'd1);

    // asynchronous reset mid-stream
    step(1, 0, 0, 0, 8'h66);
    step(1, 0, 0, 0, 8'h77);
    step(1, 0, 0, 0, 8'h88);
    step(1, 0, 0, 0, 8'h99);
    chk_err("pre_rst", 1'b1, 1'b0);
    step(0, 1, 0, 0, 8'h00);
    chk("pre_rst.dout", 32'(data_out_0), 32'h55);
    #2 rst_n = 1'b0;
    #1;
    chk_status("async_rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_err("async_rst", 1'b0, 1'b0);
    chk("async_rst.dout", 32'(data_out_0), 32'h0);
    chk("async_rst.dout_fwft", 32'(data_out_1), 32'h0);
    #2 rst_n = 1'b1;
    step(1, 0, 0, 0, 8'h12);
    chk_status("after_rst", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("after_rst.dout_fwft", 32'(data_out_1), 32'h12);
    step(0, 1, 0, 0, 8'h00);
    chk("after_rst.dout", 32'(data_out_0), 32'h12);
    chk_err("after_rst", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_adv.md
FIFO_ADV -- requirements
Module: fifo_adv

Interface
REQ-001 The block SHALL have parameter N_BITS, default 8, data word width in bits (>=1).
REQ-002 The block SHALL have parameter N_SIZE, default 4, storage depth in words (>=2; need not be a power of two).
REQ-003 The block SHALL have parameter AF_THRESH, default N_SIZE-1, almost_full level in words (1..N_SIZE).
REQ-004 The block SHALL have parameter AE_THRESH, default 1, almost_empty level in words (0..N_SIZE-1).
REQ-005 The block SHALL have parameter FWFT, default 0, read mode (0 = registered read, 1 = first-word fall-through).
REQ-006 The block SHALL run on one clock with asynchronous, active-low reset.
REQ-007 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-009 The block SHALL have port push, input, 1 bit, write request.
REQ-010 The block SHALL have port pop, input, 1 bit, read request.
REQ-011 The block SHALL have port flush, input, 1 bit, synchronous clear of contents.
REQ-012 The block SHALL have port err_clr, input, 1 bit, clears the sticky error flags.
REQ-013 The block SHALL have port data_in, input, N_BITS, write data.
REQ-014 The block SHALL have port data_out, output, N_BITS, read data.
REQ-015 The block SHALL have outputs full, empty, almost_full, almost_empty, each 1 bit, occupancy status.
REQ-016 The block SHALL have port count, output, $clog2(N_SIZE+1) bits, current occupancy.
REQ-017 The block SHALL have outputs overflow and underflow, each 1 bit, sticky error flags.

Function
REQ-018 Occupancy SHALL be tracked in registered read and write pointers plus a count register; each pointer wraps from N_SIZE-1 to 0.
REQ-019 The status outputs SHALL be decoded combinationally from count: full = (count==N_SIZE), empty = (count==0), almost_full = (count>=AF_THRESH), almost_empty = (count<=AE_THRESH).
REQ-020 A pop SHALL be accepted iff pop=1 and empty=0.
REQ-021 A push SHALL be accepted iff push=1 and either full=0 or a pop is accepted in the same cycle.
REQ-022 When full and push=pop=1, both SHALL be accepted and count SHALL stay at N_SIZE.
REQ-023 When empty and push=pop=1, only the push SHALL be accepted, count SHALL become 1, and underflow SHALL be set.
REQ-024 An accepted push SHALL write data_in at the write pointer, advance the pointer and increment count.
REQ-025 An accepted pop SHALL advance the read pointer and decrement count; simultaneous accepted push and pop SHALL leave count unchanged.
REQ-026 With FWFT=0, data_out SHALL be a register loaded with the head word on the edge of an accepted pop (1-cycle latency) and SHALL hold its value otherwise.
REQ-027 With FWFT=1, data_out SHALL combinationally present the head word while empty=0 and SHALL be 0 while empty=1; an accepted pop exposes the next word after that edge.
REQ-028 A rejected push (push=1, full=1, no accepted pop) SHALL set overflow; a rejected pop (pop=1, empty=1) SHALL set underflow.
REQ-029 err_clr=1 SHALL clear overflow and underflow on the next edge, except that a new error in the same cycle SHALL win and set its flag.
REQ-030 flush=1 SHALL take priority over push and pop: pointers and count go to 0, the FWFT=0 data_out register goes to 0, same-cycle push/pop are ignored without raising errors, and storage contents are left unchanged.

Reset
REQ-031 While rst_n=0, the block SHALL hold pointers=0, count=0, data_out=0, overflow=0, underflow=0, so that empty=1, full=0, almost_empty=1, and almost_full=0 (given AF_THRESH>=1).
REQ-032 Storage words SHALL NOT be reset.
REQ-033 Reset asserted mid-operation SHALL discard all contents immediately; the first edge after rst_n rises SHALL behave as from empty.

Verification (N_BITS=8, N_SIZE=4, AF_THRESH=3, AE_THRESH=1)
REQ-034 Verification SHALL cover: FWFT=0, push 0xFF, then pop -> data_out=0xFF one edge after the pop, empty=1, count=0.
REQ-035 Verification SHALL cover: push 0x1F,0x2F,0x3F,0x4F -> almost_full=1 at count=3; full=1 at count=4; push 0x5F -> overflow=1, count=4; pops return 0x1F..0x4F in order.
REQ-036 Verification SHALL cover: full FIFO, push=pop=1 with data 0x6F for 4 cycles -> count stays 4, overflow stays 0, wrap-around occurs, and subsequent pops return 0x6F x4.
REQ-037 Verification SHALL cover: empty FIFO, push=pop=1 with data 0x7F -> underflow=1 and count=1; err_clr -> underflow=0.
REQ-038 Verification SHALL cover: FWFT=1, push 0xA5 -> data_out=0xA5 the cycle after the push with no pop; pop -> data_out=0 and empty=1.
REQ-039 Verification SHALL cover: count=3 then flush=1 with push=1 -> count=0, empty=1, no error flags set; also rst_n pulsed low mid-stream -> all outputs at reset values asynchronously.
